// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add fixed-point multiplier:
// default operand sizes, derived-width helpers and the FSM encoding.
package shift_add_mult_pkg;

  localparam int DEF_NI = 8;
  localparam int DEF_NF = 8;

  // Multiplicand width, format NI.NF
  function automatic int mcand_w(input int ni, input int nf);
    return ni + nf;
  endfunction

  // Full product width, format 2NI.NF
  function automatic int prod_w(input int ni, input int nf);
    return 2 * ni + nf;
  endfunction

  // Iteration counter width
  function automatic int cnt_w(input int ni);
    return $clog2(ni) + 1;
  endfunction

  localparam int DEF_MCAND_W = mcand_w(DEF_NI, DEF_NF);
  localparam int DEF_PROD_W  = prod_w(DEF_NI, DEF_NF);
  localparam int DEF_CNT_W   = cnt_w(DEF_NI);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: unsigned NI.NF multiplicand times
// unsigned NI-bit multiplier, one multiplier bit per clock, LSB first.
//
// Handshake: start is sampled only while idle (state=IDLE, busy=0); a start
// seen on a clock edge latches both operands and the block is busy for
// exactly NI cycles. ready pulses for one cycle when the new product,
// result_int and overflow become visible; start may be asserted during
// that ready cycle for back-to-back operation. There is no backpressure.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int NF = DEF_NF,
  parameter int NI = DEF_NI
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NI+NF-1:0]      multiplicand,
  input  logic [NI-1:0]         multiplier,
  output logic [2*NI+NF-1:0]    product,
  output logic [NI-1:0]         result_int,
  output logic                  overflow,
  output logic                  busy,
  output logic                  ready,
  output state_t                state
);

  localparam int MW = mcand_w(NI, NF);
  localparam int PW = prod_w(NI, NF);
  localparam int CW = cnt_w(NI);
  localparam int SW = MW + 1;

  logic [CW-1:0] n;
  logic [PW-1:0] acc;
  logic [MW-1:0] mcand_q;
  logic [NI-1:0] mplier_q;

  logic          bit_n;
  logic          last;
  logic [MW-1:0] window;
  logic [SW-1:0] sum;
  logic [PW-1:0] sum_wide;
  logic [PW-1:0] mask;
  logic [PW-1:0] acc_next;

  // One accumulate step. Before step n the accumulator is below
  // mcand*2^n, so only bits [n+MW-1:n] can be nonzero above bit n and an
  // MW+1-bit add on that window captures the full carry.
  always_comb begin
    bit_n    = |(mplier_q & (NI'(1) << n));
    last     = (n == CW'(NI - 1));
    window   = MW'(acc >> n);
    sum      = {1'b0, window} + {1'b0, mcand_q};
    sum_wide = PW'(sum) << n;
    mask     = PW'({SW{1'b1}}) << n;
    acc_next = acc;
    if (bit_n) begin
      acc_next = (acc & ~mask) | sum_wide;
    end
  end

  // Control FSM with registered outputs; results change only at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n          <= '0;
      acc        <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      product    <= '0;
      result_int <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            mcand_q  <= multiplicand;
            mplier_q <= multiplier;
            acc      <= '0;
            n        <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          n   <= n + CW'(1);
          if (last) begin
            product    <= acc_next;
            result_int <= acc_next[NF+NI-1:NF];
            overflow   <= |acc_next[PW-1:NF+NI];
            busy       <= 1'b0;
            ready      <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult (NI=8, NF=8): table of hand-computed
// products plus hand-written back-to-back, ignored-start and abort cases.
module tb_shift_add_mult;
  import shift_add_mult_pkg::*;

  localparam int NI = 8;
  localparam int NF = 8;
  localparam int MW = NI + NF;
  localparam int PW = 2 * NI + NF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [MW-1:0] multiplicand;
  logic [NI-1:0] multiplier;
  logic [PW-1:0] product;
  logic [NI-1:0] result_int;
  logic          overflow;
  logic          busy;
  logic          ready;
  state_t        state;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic [MW-1:0] mc;
    logic [NI-1:0] mp;
    logic [PW-1:0] prod;
    logic [NI-1:0] rint;
    logic          ovf;
  } vec_t;

  vec_t vecs[11];

  shift_add_mult #(.NF(NF), .NI(NI)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .result_int   (result_int),
    .overflow     (overflow),
    .busy         (busy),
    .ready        (ready),
    .state        (state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a clock edge; start is seen on the following edge.
  task automatic launch(input logic [MW-1:0] mc, input logic [NI-1:0] mp, input logic [PW-1:0] exp_p);
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    exp_q.push_back(exp_p);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for ready (bounded), counting cycles and busy cycles, and noting
  // whether the visible product moved before completion.
  task automatic wait_done(output int cyc, output int bcnt, output bit changed);
    logic [PW-1:0] p0;
    p0      = product;
    cyc     = 0;
    bcnt    = busy ? 1 : 0;
    changed = 1'b0;
    while (!ready && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
      if (!ready && product !== p0) changed = 1'b1;
    end
  endtask

  task automatic check_result(input string name, input logic [NI-1:0] rint, input logic ovf);
    logic [PW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no expected product queued", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " product"}, 32'(product), 32'(e));
      check({name, " result_int"}, 32'(result_int), 32'(rint));
      check({name, " overflow"}, 32'(overflow), 32'(ovf));
    end
  endtask

  initial begin
    int cyc, bcnt, saw_ready;
    bit changed;
    logic [PW-1:0] held;

    vecs[0]  = '{16'h0280, 8'h04, 24'h000A00, 8'h0A, 1'b0};
    vecs[1]  = '{16'hFFFF, 8'hFF, 24'hFEFF01, 8'hFF, 1'b1};
    vecs[2]  = '{16'h1234, 8'h00, 24'h000000, 8'h00, 1'b0};
    vecs[3]  = '{16'h0100, 8'h03, 24'h000300, 8'h03, 1'b0};
    vecs[4]  = '{16'h0000, 8'hFF, 24'h000000, 8'h00, 1'b0};
    vecs[5]  = '{16'h8000, 8'h02, 24'h010000, 8'h00, 1'b1};
    vecs[6]  = '{16'h0180, 8'h0A, 24'h000F00, 8'h0F, 1'b0};
    vecs[7]  = '{16'h00FF, 8'hFF, 24'h00FE01, 8'hFE, 1'b0};
    vecs[8]  = '{16'h0001, 8'h80, 24'h000080, 8'h00, 1'b0};
    vecs[9]  = '{16'hFF00, 8'h01, 24'h00FF00, 8'hFF, 1'b0};
    vecs[10] = '{16'hABCD, 8'h12, 24'h0C146A, 8'h14, 1'b1};

    // Reset
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset product", 32'(product), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset ready", 32'(ready), 32'h0);
    check("reset state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table of products
    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].mc, vecs[i].mp, vecs[i].prod);
      check($sformatf("v%0d busy after start", i), 32'(busy), 32'h1);
      wait_done(cyc, bcnt, changed);
      check($sformatf("v%0d latency", i), 32'(cyc), 32'd8);
      check($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'd8);
      check($sformatf("v%0d early update", i), 32'(changed), 32'h0);
      check_result($sformatf("v%0d", i), vecs[i].rint, vecs[i].ovf);
      held = product;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("v%0d ready one cycle", i), 32'(ready), 32'h0);
      check($sformatf("v%0d hold product", i), 32'(product), 32'(held));
    end

    // Zero multiplier, then a start during the ready cycle
    launch(16'h5A5A, 8'h00, 24'h000000);
    wait_done(cyc, bcnt, changed);
    check("b2b first latency", 32'(cyc), 32'd8);
    check_result("b2b first", 8'h00, 1'b0);
    launch(16'h0100, 8'h03, 24'h000300);
    check("b2b accepted", 32'(busy), 32'h1);
    check("b2b ready dropped", 32'(ready), 32'h0);
    wait_done(cyc, bcnt, changed);
    check("b2b second latency", 32'(cyc), 32'd8);
    check_result("b2b second", 8'h03, 1'b0);
    @(posedge clk);
    #1;

    // Start pulsed mid-run is ignored
    launch(16'h0280, 8'h04, 24'h000A00);
    bcnt = busy ? 1 : 0;
    saw_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        multiplicand = 16'hFFFF;
        multiplier   = 8'hFF;
        start        = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) bcnt++;
      if (ready) saw_ready++;
    end
    check("ignore ready at 8", 32'(ready), 32'h1);
    check("ignore ready count", 32'(saw_ready), 32'd1);
    check("ignore busy cycles", 32'(bcnt), 32'd8);
    check_result("ignore", 8'h0A, 1'b0);
    @(posedge clk);
    #1;
    check("ignore no rerun", 32'(busy), 32'h0);

    // Reset in cycle 4 of RUN aborts
    multiplicand = 16'hFFFF;
    multiplier   = 8'hFF;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'h0);
    check("abort product", 32'(product), 32'h0);
    check("abort state", 32'(state), 32'(IDLE));
    saw_ready = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ready) saw_ready++;
    end
    check("abort no ready", 32'(saw_ready), 32'd0);
    check("abort product held", 32'(product), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter NF, default 8: number of fraction bits of the fixed-point multiplicand.
REQ-002 SHALL have parameter NI, default 8: number of integer bits of the multiplicand, and the width of the multiplier.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-006 SHALL have port multiplicand, input, NI+NF bits: unsigned fixed-point operand, format NI.NF.
REQ-007 SHALL have port multiplier, input, NI bits: unsigned integer operand.
REQ-008 SHALL have port product, output, 2*NI+NF bits: full unsigned product, format 2NI.NF.
REQ-009 SHALL have port result_int, output, NI bits: integer part, product[NF+NI-1:NF], truncated.
REQ-010 SHALL have port overflow, output, 1 bit: OR of product[2NI+NF-1:NF+NI].
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 SHALL have port ready, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL implement two states: IDLE and RUN.
REQ-014 In IDLE with start=1, the block SHALL latch multiplicand and multiplier, clear the accumulator and iteration counter n, and enter RUN on the same edge.
REQ-015 In IDLE with start=0, the block SHALL hold state; product, result_int and overflow SHALL keep their last values.
REQ-016 Each RUN cycle SHALL process one multiplier bit, LSB first: if bit n=1, add (multiplicand << n) into the 2NI+NF-bit accumulator; then increment n.
REQ-017 The adder SHALL be NI+NF+1 bits wide so that no carry is lost; the final product SHALL be exact, with no truncation or rounding.
REQ-018 On the RUN edge with n=NI-1, the block SHALL write the final product, return to IDLE and set ready=1 for exactly one cycle.
REQ-019 Latency SHALL be NI cycles: with start sampled at edge k, ready SHALL be high during the cycle after edge k+NI.
REQ-020 start SHALL be ignored while busy=1; latched operands SHALL not change during RUN.
REQ-021 A start asserted during the ready cycle SHALL be accepted, giving back-to-back operation with no dead cycle.
REQ-022 product, result_int and overflow SHALL update only at completion and SHALL hold until the next completion.
REQ-023 A zero operand SHALL still take NI cycles and produce product=0 and overflow=0.

Reset
REQ-024 reset=1 SHALL force state=IDLE, n=0, accumulator=0, product=0, busy=0 and ready=0 on the next edge.
REQ-025 reset SHALL take priority over start and over any RUN iteration.
REQ-026 reset asserted mid-operation SHALL abort the operation with no ready pulse and product=0.

Structure
REQ-027 A shared package SHALL define the defaults for NI and NF, the derived widths (NI+NF, 2*NI+NF, counter width $clog2(NI)+1) and the state encoding.
REQ-028 The block SHALL be a single module with no sub-module; the accumulate step is inline.

Verification (NI=8, NF=8)
REQ-029 multiplicand=0x0280 (2.5), multiplier=4 -> after 8 cycles: product=0x000A00, result_int=10, overflow=0, one ready pulse.
REQ-030 multiplicand=0xFFFF, multiplier=0xFF -> product=0xFEFF01, result_int=0xFF, overflow=1.
REQ-031 multiplier=0, any multiplicand -> ready after 8 cycles, product=0; second start on the ready cycle with 0x0100 x 3 -> product=0x000300 eight cycles later.
REQ-032 start pulsed again at cycle 3 of RUN with different operands -> ignored; first result correct; busy high for exactly 8 cycles.
REQ-033 reset asserted at cycle 4 of RUN -> next edge: busy=0, product=0; no ready pulse follows.
